// File: rtl/soc_pio_master.sv
// soc_pio_master: command-FIFO-fed Avalon-MM programmed-I/O master.
// Commands {write, addr, wdata} are queued in a small FIFO. One command is
// executed at a time as a single-cycle Avalon-MM access. Read data is
// captured after a fixed slave latency and returned as a one-cycle pulse.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rsp_rdata      read response pulse and held read data
//   busy                     FIFO non-empty or access in progress
//   address/chipselect/write_n/writedata/readdata  Avalon-MM master side
module soc_pio_master #(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W  = 1 + ADDR_W + DATA_W;
  localparam int unsigned LAT_W    = 2;
  localparam int unsigned LAT_LAST = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic               head_write;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  // Handshake and status are pure functions of registered state.
  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign busy       = !fifo_empty || (state != IDLE);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;

  assign head       = mem[rd_ptr];
  assign head_write = head[ENTRY_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy; push+pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Access sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= '0;
      writedata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            chipselect <= 1'b1;
            write_n    <= !head_write;
            address    <= head_addr;
            writedata  <= head_write ? head_wdata : '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          address    <= '0;
          writedata  <= '0;
          if (!write_n) begin
            state <= IDLE;
          end else if (READ_LATENCY == 0) begin
            // Zero-latency slave: data is valid during the access cycle.
            rsp_rdata <= readdata;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            lat_cnt <= '0;
            state   <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (lat_cnt == LAT_W'(LAT_LAST)) begin
            rsp_rdata <= readdata;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
